// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - 4-digit multiplexed common-anode 7-segment scanner for HH.MM time
//
// Purpose:
//   Scans hour-tens/hour-ones/minute-tens/minute-ones BCD digits onto a
//   4-digit common-anode display, one digit per SCAN_DIV clocks. The four
//   inputs are snapshotted once per frame so a frame never mixes two times.
//   Invalid BCD digits show a dash. A colon (dp on the h1 digit) blinks with
//   a phase that toggles every BLINK_FRAMES frames; blink_en additionally
//   blanks the whole display during phase 1.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   Defined   : an h10 digit of 0 is shown blank (anode still driven).
//   Undefined : an h10 digit of 0 is shown as "0".
//
// Ports:
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous active-high reset
//   in_h10    in   2  hour tens (BCD)
//   in_h1     in   4  hour ones (BCD)
//   in_m10    in   3  minute tens (BCD)
//   in_m1     in   4  minute ones (BCD)
//   blink_en  in   1  blank whole display during blink phase 1
//   seg_n     out  7  segments {g,f,e,d,c,b,a}, active low
//   an_n      out  4  digit anodes, active low, bit0 = m1 (rightmost)
//   dp_n      out  1  decimal point / colon, active low

module clock_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in_h10,
    input  logic [3:0] in_h1,
    input  logic [2:0] in_m10,
    input  logic [3:0] in_m1,
    input  logic       blink_en,
    output logic [6:0] seg_n,
    output logic [3:0] an_n,
    output logic       dp_n
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    // Scan position: which digit is currently lit.
    localparam logic [1:0] DIG_M1  = 2'd0;
    localparam logic [1:0] DIG_M10 = 2'd1;
    localparam logic [1:0] DIG_H1  = 2'd2;
    localparam logic [1:0] DIG_H10 = 2'd3;

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [1:0]    r_h10;
    logic [3:0]    r_h1;
    logic [2:0]    r_m10;
    logic [3:0]    r_m1;
    logic [FW-1:0] r_frame_cnt;
    logic          r_phase;
    logic [6:0]    r_seg_n;
    logic [3:0]    r_an_n;
    logic          r_dp_n;

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_nxt;
    logic          w_phase_nxt;
    logic [1:0]    w_h10_src;
    logic [3:0]    w_h1_src;
    logic [2:0]    w_m10_src;
    logic [3:0]    w_m1_src;
    logic [3:0]    w_digit;
    logic          w_valid;
    logic          w_blank;
    logic [6:0]    w_seg_n;
    logic [3:0]    w_an_n;
    logic          w_dp_n;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = SEG_DASH;
        endcase
    endfunction

    assign w_tick    = (r_presc == PW'(SCAN_DIV - 1));
    assign w_wrap    = w_tick && (r_idx == DIG_H10);
    assign w_idx_nxt = r_idx + 2'd1;

    // On the wrap edge digit 0 must already show the values being captured,
    // so the decode path bypasses the snapshot registers on that edge.
    assign w_h10_src = w_wrap ? in_h10 : r_h10;
    assign w_h1_src  = w_wrap ? in_h1  : r_h1;
    assign w_m10_src = w_wrap ? in_m10 : r_m10;
    assign w_m1_src  = w_wrap ? in_m1  : r_m1;

    // Outputs are computed for the digit being entered, so a phase toggle on
    // the wrap edge already governs digit 0 of the new frame.
    assign w_phase_nxt = (w_wrap && (r_frame_cnt == FW'(BLINK_FRAMES - 1)))
                         ? ~r_phase : r_phase;

    always_comb begin
        w_digit = 4'd0;
        w_valid = 1'b1;
        w_blank = 1'b0;
        case (w_idx_nxt)
            DIG_M1: begin
                w_digit = w_m1_src;
                w_valid = (w_m1_src <= 4'd9);
            end
            DIG_M10: begin
                w_digit = {1'b0, w_m10_src};
                w_valid = (w_m10_src <= 3'd5);
            end
            DIG_H1: begin
                w_digit = w_h1_src;
                // 24-hour clock: hours 24..29 are not legal times.
                w_valid = (w_h1_src <= 4'd9) &&
                          !((w_h10_src == 2'd2) && (w_h1_src > 4'd3));
            end
            default: begin
                w_digit = {2'b00, w_h10_src};
                w_valid = (w_h10_src <= 2'd2);
`ifdef LEADING_ZERO_BLANK_EN
                w_blank = (w_h10_src == 2'd0);
`endif
            end
        endcase
    end

    always_comb begin
        w_seg_n = f_seg(w_digit);
        if (!w_valid) begin
            w_seg_n = SEG_DASH;
        end else if (w_blank) begin
            w_seg_n = SEG_BLANK;
        end
    end

    always_comb begin
        w_an_n = 4'b1111;
        case (w_idx_nxt)
            DIG_M1:  w_an_n = 4'b1110;
            DIG_M10: w_an_n = 4'b1101;
            DIG_H1:  w_an_n = 4'b1011;
            default: w_an_n = 4'b0111;
        endcase
        w_dp_n = !((w_idx_nxt == DIG_H1) && !w_phase_nxt);
        // Whole-display blink blanks anodes and colon; segments keep scanning.
        if (blink_en && w_phase_nxt) begin
            w_an_n = 4'b1111;
            w_dp_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc     <= '0;
            r_idx       <= DIG_H10;
            r_h10       <= '0;
            r_h1        <= '0;
            r_m10       <= '0;
            r_m1        <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
            r_seg_n     <= SEG_BLANK;
            r_an_n      <= 4'b1111;
            r_dp_n      <= 1'b1;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx   <= w_idx_nxt;
                r_seg_n <= w_seg_n;
                r_an_n  <= w_an_n;
                r_dp_n  <= w_dp_n;
            end
            if (w_wrap) begin
                r_h10       <= in_h10;
                r_h1        <= in_h1;
                r_m10       <= in_m10;
                r_m1        <= in_m1;
                r_phase     <= w_phase_nxt;
                r_frame_cnt <= (r_frame_cnt == FW'(BLINK_FRAMES - 1))
                               ? '0 : r_frame_cnt + FW'(1);
            end
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;
    assign dp_n  = r_dp_n;

endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - directed self-checking bench for clock_display_scan

module tb_clock_display_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] in_h10;
    logic [3:0] in_h1;
    logic [2:0] in_m10;
    logic [3:0] in_m1;
    logic       blink_en;
    logic [6:0] seg_n;
    logic [3:0] an_n;
    logic       dp_n;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] SB = 7'b1111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] S_H10_ZERO = SB;
`else
    localparam logic [6:0] S_H10_ZERO = S0;
`endif

    clock_display_scan #(
        .SCAN_DIV     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_h10   (in_h10),
        .in_h1    (in_h1),
        .in_m10   (in_m10),
        .in_m1    (in_m1),
        .blink_en (blink_en),
        .seg_n    (seg_n),
        .an_n     (an_n),
        .dp_n     (dp_n)
    );

    always #5 clk = ~clk;

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] an, input logic [6:0] seg,
                       input logic dp);
        n_checks++;
        assert ({an_n, seg_n, dp_n} === {an, seg, dp})
        else begin
            n_fail++;
            $error("FAIL %s observed an=%b seg=%b dp=%b expected an=%b seg=%b dp=%b",
                   tag, an_n, seg_n, dp_n, an, seg, dp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; blink_en = 1'b0;
        in_h10 = 2'd0; in_h1 = 4'd9; in_m10 = 3'd0; in_m1 = 4'd5;
        edges(2);
        chk("reset", 4'b1111, SB, 1'b1);
        rst = 1'b0;
        edges(1); chk("post_rst_e1", 4'b1111, SB, 1'b1);
        edges(1); chk("post_rst_e2", 4'b1111, SB, 1'b1);
        edges(1); chk("post_rst_e3", 4'b1111, SB, 1'b1);

        // Frame 1 (phase 0): 09:05
        edges(1); chk("f1_d0", 4'b1110, S5, 1'b1);
        edges(4); chk("f1_d1", 4'b1101, S0, 1'b1);
        edges(4); chk("f1_d2_colon", 4'b1011, S9, 1'b0);
        in_h10 = 2'd1; in_h1 = 4'd2; in_m10 = 3'd3; in_m1 = 4'd4;
        edges(4); chk("f1_d3_h10_zero", 4'b0111, S_H10_ZERO, 1'b1);

        // Frame 2 (phase 1, no blink): 12:34
        edges(4); chk("f2_d0", 4'b1110, S4, 1'b1);
        edges(4); chk("f2_d1", 4'b1101, S3, 1'b1);
        edges(4); chk("f2_d2_nocolon", 4'b1011, S2, 1'b1);
        edges(4); chk("f2_d3", 4'b0111, S1, 1'b1);

        // Frame 3 (phase 1): change m1 mid-frame, snapshot must hold
        edges(4); chk("f3_d0", 4'b1110, S4, 1'b1);
        edges(4); chk("f3_d1", 4'b1101, S3, 1'b1);
        in_m1 = 4'd5;
        edges(4); chk("f3_d2_old", 4'b1011, S2, 1'b1);
        edges(2); chk("f3_d2_hold", 4'b1011, S2, 1'b1);
        edges(2); chk("f3_d3_old", 4'b0111, S1, 1'b1);

        // Frame 4 (phase 0): 12:35
        edges(4); chk("f4_d0_new", 4'b1110, S5, 1'b1);
        in_h10 = 2'd2; in_h1 = 4'd5; in_m10 = 3'd6; in_m1 = 4'd7;
        edges(4); chk("f4_d1", 4'b1101, S3, 1'b1);
        edges(4); chk("f4_d2_colon", 4'b1011, S2, 1'b0);
        edges(4); chk("f4_d3", 4'b0111, S1, 1'b1);

        // Frame 5 (phase 0): 25:67, h1 and m10 invalid
        edges(4); chk("f5_d0", 4'b1110, S7, 1'b1);
        edges(4); chk("f5_d1_dash", 4'b1101, SD, 1'b1);
        edges(4); chk("f5_d2_dash", 4'b1011, SD, 1'b0);
        edges(4); chk("f5_d3", 4'b0111, S2, 1'b1);
        blink_en = 1'b1;

        // Frame 6 (phase 1, blink): anodes off, segments keep scanning
        edges(4); chk("f6_d0_blank", 4'b1111, S7, 1'b1);
        edges(4); chk("f6_d1_blank", 4'b1111, SD, 1'b1);
        edges(4); chk("f6_d2_blank", 4'b1111, SD, 1'b1);
        edges(4); chk("f6_d3_blank", 4'b1111, S2, 1'b1);

        // Frame 7 (phase 1): blink_en falls mid-frame
        edges(4); chk("f7_d0_blank", 4'b1111, S7, 1'b1);
        edges(4); chk("f7_d1_blank", 4'b1111, SD, 1'b1);
        blink_en = 1'b0;
        edges(4); chk("f7_d2_restored", 4'b1011, SD, 1'b1);
        edges(4); chk("f7_d3_restored", 4'b0111, S2, 1'b1);

        // Frame 8 (phase 0): blink_en has no effect in phase 0
        edges(4); chk("f8_d0", 4'b1110, S7, 1'b1);
        blink_en = 1'b1;
        edges(4); chk("f8_d1_lit", 4'b1101, SD, 1'b1);
        edges(4); chk("f8_d2_colon", 4'b1011, SD, 1'b0);

        // Reset mid-frame
        edges(1);
        rst = 1'b1;
        edges(1); chk("midrst", 4'b1111, SB, 1'b1);
        rst = 1'b0;
        edges(1); chk("midrst_e1", 4'b1111, SB, 1'b1);
        edges(2); chk("midrst_e3", 4'b1111, SB, 1'b1);
        edges(1); chk("midrst_d0", 4'b1110, S7, 1'b1);
        blink_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
